uart_line_sender: RTL



---
 rtl/uart_line_sender_if.sv | 44 ++++
 rtl/uart_line_sender.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_line_sender_if.sv
// Host load port and UART transmit port of the line sender.
// master drives bytes/Start/TxReady; slave is the sender itself.
interface uart_line_sender_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    WrData;
  logic          WrValid;
  logic          WrReady;
  logic          Start;
  logic [7:0]    TxData;
  logic          TxValid;
  logic          TxReady;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;

  modport master (
    output WrData,
    output WrValid,
    output Start,
    output TxReady,
    input  WrReady,
    input  TxData,
    input  TxValid,
    input  Busy,
    input  Done,
    input  Count
  );

  modport slave (
    input  WrData,
    input  WrValid,
    input  Start,
    input  TxReady,
    output WrReady,
    output TxData,
    output TxValid,
    output Busy,
    output Done,
    output Count
  );
endinterface

// File: rtl/uart_line_sender.sv
// Line-buffered byte injector for the UART transmit port.
// Loads bytes while idle, then drains a whole line on terminator or Start.
module uart_line_sender #(
  parameter int         DEPTH      = 32,
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] TERMINATOR = 8'h0A
) (
  input logic               Clock,
  input logic               Reset,
  uart_line_sender_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FINISH
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    tx_data;

  logic          full;
  logic          wr_ready;
  logic          load;
  logic          req;
  logic          last;
  logic [CW-1:0] count_load;
  logic [AW-1:0] rd_next;
  logic [7:0]    head;

  assign full       = (count == FULL);
  assign wr_ready   = (state == IDLE) && !full;
  assign load       = bus.WrValid && wr_ready;
  assign req        = (state == IDLE) &&
                      (bus.Start ||
                       (load && bus.WrData == TERMINATOR));
  assign count_load = count + CW'(load);
  assign last       = (count == CW'(1));
  assign rd_next    = rd_ptr + AW'(1);

  // An empty buffer means the oldest byte is the one arriving now
  assign head = (count == '0) ? bus.WrData : mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (load) begin
      mem[wr_ptr] <= bus.WrData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      gap_cnt <= '0;
      tx_data <= '0;
    end else begin
      if (load) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      unique case (state)
        IDLE: begin
          count <= count_load;
          if (req) begin
            if (count_load != '0) begin
              state   <= SEND;
              tx_data <= head;
            end else begin
              state <= FINISH;
            end
          end
        end
        SEND: begin
          if (bus.TxReady) begin
            rd_ptr <= rd_next;
            count  <= count - CW'(1);
            if (last) begin
              state <= FINISH;
            end else if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              tx_data <= mem[rd_next];
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state   <= SEND;
            tx_data <= mem[rd_ptr];
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.WrReady = wr_ready;
  assign bus.TxData  = tx_data;
  assign bus.TxValid = (state == SEND);
  assign bus.Busy    = (state == SEND) || (state == GAP);
  assign bus.Done    = (state == FINISH);
  assign bus.Count   = count;
endmodule
